// File: rtl/nand_vector_sequencer.sv
// nand_vector_sequencer
//   Clocked stimulus-and-check stage for a 4-input NAND gate block. A sweep
//   drives {d,c,b,a} through vectors 0..15, holding each for DWELL cycles.
//   On the last dwell cycle of each vector it samples the gate response,
//   compares resp_in[0] with the expected NAND, and folds all response bits
//   into an 8-bit MISR.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   start            single-cycle sweep request (accepted in IDLE or DONE)
//   a, b, c, d       applied vector, a = bit 0 (fastest), d = bit 3
//   resp_in          gate response, resp_in[0] = NAND(a,b,c,d)
//   busy             sweep running
//   done             sweep finished, held until next accepted start or reset
//   err_cnt          number of mismatching vectors (0..16)
//   first_err_valid  a mismatch has been seen in this sweep
//   first_err_vec    {d,c,b,a} of the first mismatch
//   signature        MISR over sampled responses (poly 8'h1D)

module nand_vector_sequencer #(
    parameter int unsigned DWELL  = 50,
    parameter int unsigned RESP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic [4:0]        err_cnt,
    output logic              first_err_valid,
    output logic [3:0]        first_err_vec,
    output logic [7:0]        signature
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [7:0] DwellLast = 8'(DWELL - 1);

    state_e     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [7:0] dwell_q, dwell_d;
    logic [4:0] err_q, err_d;
    logic       fev_valid_q, fev_valid_d;
    logic [3:0] fev_q, fev_d;
    logic [7:0] sig_q, sig_d;
    logic [7:0] resp_ext;
    logic       mismatch;

    always_comb begin
        resp_ext = '0;
        resp_ext[RESP_W-1:0] = resp_in;
    end

    assign mismatch = (resp_in[0] != ~(&vec_q));

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dwell_d     = dwell_q;
        err_d       = err_q;
        fev_valid_d = fev_valid_q;
        fev_d       = fev_q;
        sig_d       = sig_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRun;
                    vec_d       = '0;
                    dwell_d     = '0;
                    err_d       = '0;
                    fev_valid_d = 1'b0;
                    fev_d       = '0;
                    sig_d       = '0;
                end
            end
            StRun: begin
                if (dwell_q == DwellLast) begin
                    // Sample point: gate output has settled for the whole dwell.
                    if (mismatch) begin
                        err_d = err_q + 5'd1;
                        if (!fev_valid_q) begin
                            fev_valid_d = 1'b1;
                            fev_d       = vec_q;
                        end
                    end
                    sig_d   = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00) ^ resp_ext;
                    dwell_d = '0;
                    if (vec_q == 4'hF) begin
                        state_d = StDone;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            vec_q       <= '0;
            dwell_q     <= '0;
            err_q       <= '0;
            fev_valid_q <= 1'b0;
            fev_q       <= '0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dwell_q     <= dwell_d;
            err_q       <= err_d;
            fev_valid_q <= fev_valid_d;
            fev_q       <= fev_d;
            sig_q       <= sig_d;
        end
    end

    // Vector lines are only driven while a sweep runs; IDLE and DONE show 0.
    always_comb begin
        {d, c, b, a} = (state_q == StRun) ? vec_q : 4'h0;
    end

    assign busy            = (state_q == StRun);
    assign done            = (state_q == StDone);
    assign err_cnt         = err_q;
    assign first_err_valid = fev_valid_q;
    assign first_err_vec   = fev_q;
    assign signature       = sig_q;

endmodule

// File: tb/tb_nand_vector_sequencer.sv
module tb_nand_vector_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start2;

    // DUT 1: DWELL=4, RESP_W=3
    logic       a, b, c, d, busy, done, fev_valid;
    logic [4:0] err_cnt;
    logic [3:0] fev;
    logic [7:0] sig;
    logic [2:0] resp;

    // DUT 2: DWELL=2, RESP_W=1
    logic       a2, b2, c2, d2, busy2, done2, fev_valid2;
    logic [4:0] err_cnt2;
    logic [3:0] fev2;
    logic [7:0] sig2;
    logic [0:0] resp2;

    int   mode;   // 0 correct gate, 1 stuck-at-1, 2 stuck-at-0
    logic bad2;   // drive an inverted response into DUT 2
    int   total;
    int   bad;

    // Gate block emulation
    assign resp  = {2'b00, (mode == 0) ? ~(a & b & c & d) : ((mode == 1) ? 1'b1 : 1'b0)};
    assign resp2 = bad2 ? (a2 & b2 & c2 & d2) : ~(a2 & b2 & c2 & d2);

    nand_vector_sequencer #(.DWELL(4), .RESP_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .d(d),
        .resp_in(resp), .busy(busy), .done(done), .err_cnt(err_cnt),
        .first_err_valid(fev_valid), .first_err_vec(fev), .signature(sig)
    );

    nand_vector_sequencer #(.DWELL(2), .RESP_W(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2), .d(d2),
        .resp_in(resp2), .busy(busy2), .done(done2), .err_cnt(err_cnt2),
        .first_err_valid(fev_valid2), .first_err_vec(fev2), .signature(sig2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_sig(input int m);
        logic [7:0] s;
        logic [3:0] k;
        logic       r;
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            r = (m == 0) ? ~(&k) : ((m == 1) ? 1'b1 : 1'b0);
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, r};
        end
        return s;
    endfunction

    // One full sweep on DUT 1 with expected statistics.
    task automatic sweep1(input int m, input bit pulse_run, input string tag,
                          input int exp_err, input bit exp_fv, input logic [3:0] exp_fvec);
        logic [7:0] exp_sig;
        exp_sig = ref_sig(m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err_cnt !== 5'd0 || sig !== 8'h00 || fev_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s_clear: err=%0d sig=%h fv=%b done=%b want 0 00 0 0",
                     tag, err_cnt, sig, fev_valid, done);
        end
        for (int i = 0; i < 64; i++) begin
            total++;
            if ({d, c, b, a} !== 4'(i / 4) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s_run cyc %0d: vec=%h busy=%b done=%b want vec=%h busy=1 done=0",
                         tag, i, {d, c, b, a}, busy, done, 4'(i / 4));
            end
            start = pulse_run && (i % 7 == 2);
            tick();
            start = 1'b0;
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || {d, c, b, a} !== 4'h0) begin
            bad++;
            $display("FAIL %s_end: busy=%b done=%b vec=%h want 0 1 0", tag, busy, done, {d, c, b, a});
        end
        total++;
        if (err_cnt !== 5'(exp_err) || fev_valid !== exp_fv) begin
            bad++;
            $display("FAIL %s_err: err=%0d fv=%b want %0d %b", tag, err_cnt, fev_valid, exp_err, exp_fv);
        end
        if (exp_fv) begin
            total++;
            if (fev !== exp_fvec) begin
                bad++;
                $display("FAIL %s_fvec: got %h want %h", tag, fev, exp_fvec);
            end
        end
        total++;
        if (sig !== exp_sig) begin
            bad++;
            $display("FAIL %s_sig: got %h want %h", tag, sig, exp_sig);
        end
        // DONE holds its results
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== 5'(exp_err) || sig !== exp_sig) begin
            bad++;
            $display("FAIL %s_hold: done=%b busy=%b err=%0d sig=%h want 1 0 %0d %h",
                     tag, done, busy, err_cnt, sig, exp_err, exp_sig);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({d, c, b, a, busy, done, fev_valid} !== 7'b0 || err_cnt !== 5'd0 || fev !== 4'h0
            || sig !== 8'h00) begin
            bad++;
            $display("FAIL reset1: vec=%h busy=%b done=%b err=%0d fv=%b fvec=%h sig=%h want all 0",
                     {d, c, b, a}, busy, done, err_cnt, fev_valid, fev, sig);
        end
        total++;
        if ({d2, c2, b2, a2, busy2, done2, fev_valid2} !== 7'b0 || err_cnt2 !== 5'd0
            || sig2 !== 8'h00) begin
            bad++;
            $display("FAIL reset2: vec=%h busy=%b done=%b err=%0d sig=%h want all 0",
                     {d2, c2, b2, a2}, busy2, done2, err_cnt2, sig2);
        end
    endtask

    task automatic test_correct;
        sweep1(0, 1'b0, "correct", 0, 1'b0, 4'h0);
    endtask

    task automatic test_stuck1;
        sweep1(1, 1'b0, "stuck1", 1, 1'b1, 4'hF);
    endtask

    // Starts from DONE, so this also checks the clear-on-restart path.
    task automatic test_stuck0;
        sweep1(2, 1'b0, "stuck0", 15, 1'b1, 4'h0);
    endtask

    task automatic test_back_to_back;
        sweep1(0, 1'b1, "runpulse", 0, 1'b0, 4'h0);
        sweep1(0, 1'b0, "repeat", 0, 1'b0, 4'h0);
    endtask

    task automatic test_reset_mid_run;
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 29; i++) tick();
        total++;
        if ({d, c, b, a} !== 4'h7 || err_cnt !== 5'd7) begin
            bad++;
            $display("FAIL midrun_pre: vec=%h err=%0d want 7 7", {d, c, b, a}, err_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({d, c, b, a, busy, done, fev_valid} !== 7'b0 || err_cnt !== 5'd0 || fev !== 4'h0
            || sig !== 8'h00) begin
            bad++;
            $display("FAIL midrun_rst: vec=%h busy=%b done=%b err=%0d fv=%b sig=%h want all 0",
                     {d, c, b, a}, busy, done, err_cnt, fev_valid, sig);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrun_idle: busy=%b done=%b want 0 0", busy, done);
        end
        sweep1(0, 1'b0, "afterrst", 0, 1'b0, 4'h0);
    endtask

    task automatic test_min_dwell;
        logic [7:0] exp_sig;
        exp_sig = ref_sig(0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            // Wrong response on the first dwell cycle, correct on the sampled one.
            bad2 = (i % 2 == 0);
            total++;
            if ({d2, c2, b2, a2} !== 4'(i / 2) || busy2 !== 1'b1 || done2 !== 1'b0) begin
                bad++;
                $display("FAIL dwell2_run cyc %0d: vec=%h busy=%b done=%b want vec=%h busy=1 done=0",
                         i, {d2, c2, b2, a2}, busy2, done2, 4'(i / 2));
            end
            tick();
        end
        bad2 = 1'b0;
        total++;
        if (done2 !== 1'b1 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL dwell2_end: done=%b busy=%b want 1 0", done2, busy2);
        end
        total++;
        if (err_cnt2 !== 5'd0 || fev_valid2 !== 1'b0 || sig2 !== exp_sig) begin
            bad++;
            $display("FAIL dwell2_res: err=%0d fv=%b sig=%h want 0 0 %h",
                     err_cnt2, fev_valid2, sig2, exp_sig);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        bad2   = 1'b0;
        test_reset();
        test_correct();
        test_stuck1();
        test_stuck0();
        test_back_to_back();
        test_reset_mid_run();
        test_min_dwell();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
